// File: rtl/led_pkg.sv
// Types and widths shared by the LED frame sequencer, the WS2812 driver and the top level.
package led_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        LOAD,
        WAIT,
        LATCH
    } seq_state_t;

    localparam int PIXEL_W = 24;
    localparam int WORD_W  = 16;

endpackage

// File: rtl/latch_timer.sv
// Loadable down-counter that times the idle line after the last pixel of a frame.
module latch_timer #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load wins over counting; the counter parks at zero rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/led_frame_sequencer.sv
// Reads a frame of pixels from SPRAM (two words per pixel), hands each assembled
// {G,R,B} colour to the WS2812 driver, then holds the line idle for the latch gap.
module led_frame_sequencer
    import led_pkg::*;
#(
    parameter int NUM_LEDS     = 64,
    parameter int ADDR_W       = 14,
    parameter int LATCH_CYCLES = 4000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_re,
    input  logic [WORD_W-1:0]  mem_rdata,
    output logic [PIXEL_W-1:0] rgb,
    output logic               load,
    input  logic               done,
    output logic               busy,
    output logic               frame_done
);

    localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int CNT_W = $clog2(LATCH_CYCLES);

    seq_state_t         state;
    seq_state_t         state_next;
    logic [IDX_W-1:0]   idx;
    logic [ADDR_W-1:0]  base_reg;
    logic [WORD_W-1:0]  gr_reg;
    logic [PIXEL_W-1:0] rgb_reg;
    logic [ADDR_W-1:0]  pix_addr;
    logic               last_pixel;
    logic               timer_load;
    logic               timer_en;
    logic               timer_zero;

    // Address arithmetic deliberately wraps modulo 2^ADDR_W.
    assign pix_addr   = base_reg + (ADDR_W'(idx) << 1);
    assign last_pixel = (idx == IDX_W'(NUM_LEDS - 1));
    assign timer_load = (state == WAIT) && done && last_pixel;
    assign rgb        = rgb_reg;

    latch_timer #(
        .WIDTH (CNT_W)
    ) u_latch_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (CNT_W'(LATCH_CYCLES - 1)),
        .en         (timer_en),
        .zero       (timer_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            base_reg <= '0;
            gr_reg   <= '0;
            rgb_reg  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_reg <= base_addr;
                        idx      <= '0;
                    end
                end
                RD1:  gr_reg  <= mem_rdata;
                // The blue word's upper byte is padding and is dropped here.
                RD2:  rgb_reg <= {gr_reg, mem_rdata[7:0]};
                WAIT: begin
                    if (done && !last_pixel) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        mem_re     = 1'b0;
        mem_addr   = '0;
        load       = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        timer_en   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = RD0;
            end
            RD0: begin
                mem_re     = 1'b1;
                mem_addr   = pix_addr;
                state_next = RD1;
            end
            RD1: begin
                mem_re     = 1'b1;
                mem_addr   = pix_addr + 1'b1;
                state_next = RD2;
            end
            RD2:  state_next = LOAD;
            LOAD: begin
                load       = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (done) state_next = last_pixel ? LATCH : RD0;
            end
            LATCH: begin
                timer_en = 1'b1;
                if (timer_zero) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Self-checking bench: three sequencer instances (3-pixel frame, 2-pixel address wrap,
// 1-pixel short latch) each fed by a behavioural single-port RAM.
module tb_led_frame_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: NUM_LEDS=3, ADDR_W=6, LATCH_CYCLES=12
    logic        start_a, done_a, re_a, load_a, busy_a, fd_a;
    logic [5:0]  base_a, addr_a;
    logic [15:0] rdata_a;
    logic [23:0] rgb_a;
    logic [15:0] ram_a [0:63];

    // Instance B: NUM_LEDS=2, ADDR_W=4, LATCH_CYCLES=3
    logic        start_b, done_b, re_b, load_b, busy_b, fd_b;
    logic [3:0]  base_b, addr_b;
    logic [15:0] rdata_b;
    logic [23:0] rgb_b;
    logic [15:0] ram_b [0:15];

    // Instance C: NUM_LEDS=1, ADDR_W=6, LATCH_CYCLES=2
    logic        start_c, done_c, re_c, load_c, busy_c, fd_c;
    logic [5:0]  base_c, addr_c;
    logic [15:0] rdata_c;
    logic [23:0] rgb_c;
    logic [15:0] ram_c [0:63];

    led_frame_sequencer #(.NUM_LEDS(3), .ADDR_W(6), .LATCH_CYCLES(12)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .base_addr(base_a),
        .mem_addr(addr_a), .mem_re(re_a), .mem_rdata(rdata_a), .rgb(rgb_a),
        .load(load_a), .done(done_a), .busy(busy_a), .frame_done(fd_a)
    );

    led_frame_sequencer #(.NUM_LEDS(2), .ADDR_W(4), .LATCH_CYCLES(3)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .base_addr(base_b),
        .mem_addr(addr_b), .mem_re(re_b), .mem_rdata(rdata_b), .rgb(rgb_b),
        .load(load_b), .done(done_b), .busy(busy_b), .frame_done(fd_b)
    );

    led_frame_sequencer #(.NUM_LEDS(1), .ADDR_W(6), .LATCH_CYCLES(2)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .base_addr(base_c),
        .mem_addr(addr_c), .mem_re(re_c), .mem_rdata(rdata_c), .rgb(rgb_c),
        .load(load_c), .done(done_c), .busy(busy_c), .frame_done(fd_c)
    );

    // RAM models: read data appears the cycle after mem_re.
    always @(posedge clk) begin
        if (re_a) rdata_a <= ram_a[addr_a];
        if (re_b) rdata_b <= ram_b[addr_b];
        if (re_c) rdata_c <= ram_c[addr_c];
    end

    typedef struct {
        logic        start;
        logic        done;
        logic        load;
        logic [23:0] rgb;
        logic        busy;
        logic        fd;
        logic        re;
        logic [5:0]  addr;
    } vec_t;

    vec_t vecs [11];
    logic [23:0] exp_a [3];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic d);
        start_c = s;
        done_c  = d;
        @(posedge clk);
        #1;
    endtask

    // One frame on instance A with a driver model answering done 10 cycles after each load.
    task automatic run_frame_a(input bit inject);
        int loads = 0;
        int last_load = -100;
        int last_done = -100;
        int first_load = -1;
        int fd_cyc = -1;
        start_a = 1'b1;
        done_a  = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(posedge clk);
            #1;
            start_a = 1'b0;
            done_a  = 1'b0;
            if (load_a) begin
                if (loads < 3) check_output("a_rgb", rgb_a, exp_a[loads]);
                if (loads == 0) first_load = cyc;
                else check_output("a_done_to_load", cyc - last_done, 4);
                loads++;
                last_load = cyc;
            end
            if (fd_a) begin
                fd_cyc = cyc;
                if (inject) start_a = 1'b1;
                break;
            end
            if (cyc == last_load + 10) begin
                done_a    = 1'b1;
                last_done = cyc;
            end
            if (inject) begin
                if (cyc == last_load + 3) start_a = 1'b1;
                if (loads < 3 && cyc == last_done + 2) done_a = 1'b1;
                if (loads == 3 && cyc == last_done + 5) start_a = 1'b1;
            end
        end
        check_output("a_frame_done_seen", fd_cyc > 0, 1);
        check_output("a_load_count", loads, 3);
        check_output("a_first_load_latency", first_load, 4);
        check_output("a_latch_gap", fd_cyc - last_done, 12);
        @(posedge clk);
        #1;
        start_a = 1'b0;
        check_output("a_busy_after_frame", {busy_a, fd_a, load_a}, 3'b000);
    endtask

    initial begin
        int n;
        int bad;
        bit seen;
        int last;
        bit fd_seen;
        logic [3:0] addrs[$];
        logic [3:0] exp_addr [4];

        reset = 1'b1;
        start_a = 0; done_a = 0; base_a = 6'd0;
        start_b = 0; done_b = 0; base_b = 4'hE;
        start_c = 0; done_c = 0; base_c = 6'd4;
        ram_a[0] = 16'h1122; ram_a[1] = 16'h0033; ram_a[2] = 16'h4455;
        ram_a[3] = 16'h0066; ram_a[4] = 16'h7788; ram_a[5] = 16'h0099;
        ram_b[14] = 16'h0102; ram_b[15] = 16'h0003; ram_b[0] = 16'h0405; ram_b[1] = 16'h0006;
        ram_c[4] = 16'hA1B2; ram_c[5] = 16'hFFC3;
        exp_a[0] = 24'h112233; exp_a[1] = 24'h445566; exp_a[2] = 24'h778899;
        exp_addr[0] = 4'hE; exp_addr[1] = 4'hF; exp_addr[2] = 4'h0; exp_addr[3] = 4'h1;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b1, 6'd4};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b1, 6'd5};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 6'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 24'hA1B2C3, 1'b1, 1'b0, 1'b0, 6'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 24'hA1B2C3, 1'b1, 1'b0, 1'b0, 6'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 24'hA1B2C3, 1'b1, 1'b0, 1'b0, 6'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 24'hA1B2C3, 1'b1, 1'b0, 1'b0, 6'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 24'hA1B2C3, 1'b1, 1'b1, 1'b0, 6'd0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 24'hA1B2C3, 1'b0, 1'b0, 1'b0, 6'd0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 24'hA1B2C3, 1'b0, 1'b0, 1'b0, 6'd0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 24'hA1B2C3, 1'b0, 1'b0, 1'b0, 6'd0};

        repeat (2) @(posedge clk);
        #1;
        check_output("a_reset_state", {load_a, rgb_a, busy_a, fd_a, re_a, addr_a}, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single-pixel frame with a two-cycle latch, cycle by cycle.
        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i].start, vecs[i].done);
            check_output($sformatf("c_row%0d", i),
                         {load_c, rgb_c, busy_c, fd_c, re_c, addr_c},
                         {vecs[i].load, vecs[i].rgb, vecs[i].busy, vecs[i].fd, vecs[i].re, vecs[i].addr});
        end
        start_c = 1'b0;
        done_c  = 1'b0;

        // Spurious done while idle must not start anything.
        done_a = 1'b1;
        @(posedge clk);
        #1;
        done_a = 1'b0;
        check_output("a_idle_done_ignored", {busy_a, load_a}, 2'b00);

        run_frame_a(1'b0);
        run_frame_a(1'b1);
        bad = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (load_a || busy_a || fd_a) bad++;
        end
        check_output("a_no_queued_start", bad, 0);

        // Address wrap on a 4-bit RAM starting at 0xE.
        start_b = 1'b1;
        n = 0;
        last = -100;
        fd_seen = 1'b0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(posedge clk);
            #1;
            start_b = 1'b0;
            done_b  = 1'b0;
            if (re_b) addrs.push_back(addr_b);
            if (load_b) begin
                check_output("b_rgb", rgb_b, (n == 0) ? 24'h010203 : 24'h040506);
                n++;
                last = cyc;
            end
            if (fd_b) begin
                fd_seen = 1'b1;
                break;
            end
            if (cyc == last + 2) done_b = 1'b1;
        end
        check_output("b_frame_done_seen", fd_seen, 1);
        check_output("b_load_count", n, 2);
        check_output("b_addr_count", addrs.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < addrs.size()) check_output($sformatf("b_addr%0d", i), addrs[i], exp_addr[i]);
        end

        // Reset in WAIT of pixel 2 abandons the frame.
        start_a = 1'b1;
        n = 0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 40 && n < 2; cyc++) begin
            @(posedge clk);
            #1;
            start_a = 1'b0;
            done_a  = 1'b0;
            if (seen) begin
                done_a = 1'b1;
                seen   = 1'b0;
            end
            if (load_a) begin
                n++;
                seen = 1'b1;
            end
        end
        check_output("a_reached_pixel2", n, 2);
        @(posedge clk);
        #1;
        done_a = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_output("a_async_reset_outputs", {load_a, rgb_a, busy_a, fd_a, re_a, addr_a}, 0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        bad = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (load_a || busy_a || fd_a) bad++;
        end
        check_output("a_quiet_after_reset", bad, 0);
        run_frame_a(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
